// File: rtl/weight_loader.sv
// weight_loader: streams neuron-major weight words into a layer's bank of
// weight memories, one write per accepted beat, with framing checks on s_last.
module weight_loader #(
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned numWeight    = 784,
  parameter int unsigned numNeuron    = 30,
  parameter int unsigned neuronWidth  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic [numNeuron-1:0]    wen,
  output logic [addressWidth-1:0] waddr,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;

  state_t                  state, state_n;
  logic [addressWidth-1:0] wcnt, wcnt_n;
  logic [neuronWidth-1:0]  ncnt, ncnt_n;
  logic [numNeuron-1:0]    wen_n;
  logic [addressWidth-1:0] waddr_n;
  logic [dataWidth-1:0]    win_n;
  logic                    done_n;
  logic                    accept;
  logic                    last_word;
  logic                    last_neuron;
  logic                    final_beat;

  assign accept      = s_valid && s_ready;
  assign last_word   = (wcnt == addressWidth'(numWeight - 1));
  assign last_neuron = (ncnt == neuronWidth'(numNeuron - 1));
  assign final_beat  = last_word && last_neuron;

  // Next state, counters and next registered write/status values.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    ncnt_n  = ncnt;
    wen_n   = '0;
    waddr_n = waddr;
    win_n   = win;
    done_n  = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (start) begin
          state_n = LOAD;
          wcnt_n  = '0;
          ncnt_n  = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (final_beat != s_last) begin
            // Framing error: s_last disagrees with the beat position; drop it.
            state_n = ERR;
          end else begin
            wen_n   = numNeuron'(1) << ncnt;
            waddr_n = wcnt;
            win_n   = s_data;
            if (final_beat) begin
              done_n  = 1'b1;
              state_n = IDLE;
              wcnt_n  = '0;
              ncnt_n  = '0;
            end else if (last_word) begin
              wcnt_n = '0;
              ncnt_n = ncnt + neuronWidth'(1);
            end else begin
              wcnt_n = wcnt + addressWidth'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and all outputs registered; synchronous reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      ncnt    <= '0;
      wen     <= '0;
      waddr   <= '0;
      win     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      ncnt    <= ncnt_n;
      wen     <= wen_n;
      waddr   <= waddr_n;
      win     <= win_n;
      done    <= done_n;
      err     <= (state_n == ERR);
      busy    <= (state_n == LOAD);
      s_ready <= (state_n == LOAD);
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and random stimulus for weight_loader, checked
// every cycle against a flat-index behavioural model of the layer load.
module tb_weight_loader;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NW    = 3;
  localparam int unsigned NN    = 2;
  localparam int unsigned NWID  = 1;
  localparam int unsigned TOTAL = NW * NN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [NN-1:0] wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] win;
  logic          busy;
  logic          done;
  logic          err;

  weight_loader #(
    .dataWidth(DW), .addressWidth(AW), .numWeight(NW),
    .numNeuron(NN), .neuronWidth(NWID)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wen(wen), .waddr(waddr), .win(win),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=load 2=error; k = flat index of the next expected word.
  int            mode = 0;
  int            k = 0;
  bit            chk_en = 0;
  logic [NN-1:0] exp_wen;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_win;
  logic          exp_done;

  always @(posedge clk) begin
    bit fin;
    chk_en   = 1;
    exp_wen  = '0;
    exp_done = 1'b0;
    if (rst) begin
      mode = 0; k = 0; exp_waddr = '0; exp_win = '0;
    end else if (mode == 1) begin
      if (s_valid) begin
        fin = (k == TOTAL - 1);
        if (fin == s_last) begin
          exp_wen   = NN'(1) << (k / NW);
          exp_waddr = AW'(k % NW);
          exp_win   = s_data;
          if (fin) begin exp_done = 1'b1; mode = 0; k = 0; end
          else k++;
        end else begin
          mode = 2;
        end
      end
    end else if (start) begin
      mode = 1; k = 0;
    end
  end

  // Write log and done count, captured from the DUT for literal checks.
  logic [NN-1:0] log_wen[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            done_cnt = 0;

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wen", wen, exp_wen);
      check("waddr", waddr, exp_waddr);
      check("win", win, exp_win);
      check("done", done, exp_done);
      check("err", err, mode == 2);
      check("busy", busy, mode == 1);
      check("s_ready", s_ready, mode == 1);
      check("done_err_excl", done & err, 0);
      check("wen_onehot0", $countones(wen) <= 1, 1);
      if (wen != '0) begin
        log_wen.push_back(wen);
        log_addr.push_back(waddr);
        log_data.push_back(win);
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_log();
    log_wen.delete(); log_addr.delete(); log_data.delete(); done_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    @(negedge clk);
    start = 1'b0; s_valid = v; s_data = d; s_last = l;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  // Literal expectation: n writes of base+i, neuron i/3, address i%3.
  task automatic check_log(input string tag, input int n, input int base, input int ndone);
    check({tag, "_len"}, log_data.size(), n);
    check({tag, "_done"}, done_cnt, ndone);
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      check({tag, "_wen"}, log_wen[i], 1 << (i / 3));
      check({tag, "_addr"}, log_addr[i], i % 3);
      check({tag, "_data"}, log_data[i], base + i);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_wen", wen, 0);
    check("reset_ready", s_ready, 0);
    check("reset_err", err, 0);
    rst = 1'b0;

    // Clean back-to-back load.
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(16'h11 + i), i == 5);
    idle(2);
    check_log("b2b", 6, 'h11, 1);
    check("b2b_idle_ready", s_ready, 0);

    // Same load with gaps between beats.
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, DW'(16'h11 + i), i == 5);
      drive(1'b0, 16'hdead, 1'b1);
    end
    idle(1);
    check_log("gaps", 6, 'h11, 1);

    // Early s_last on beat 4.
    clear_log();
    do_start();
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h21 + i), i == 3);
    drive(1'b0, '0, 1'b0);
    check("early_err", err, 1);
    check("early_ready", s_ready, 0);
    idle(1);
    check_log("early", 3, 'h21, 0);

    // Recovery from ERR with a clean load.
    clear_log();
    do_start();
    drive(1'b0, '0, 1'b0);
    check("recover_err_clr", err, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(16'h31 + i), i == 5);
    idle(2);
    check_log("recover", 6, 'h31, 1);

    // Missing s_last on the final beat, then a 7th beat offered.
    clear_log();
    do_start();
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(16'h41 + i), 1'b0);
    idle(1);
    check("nolast_err", err, 1);
    check_log("nolast", 5, 'h41, 0);

    // Reset mid-load with s_valid held high.
    clear_log();
    do_start();
    drive(1'b1, 16'h51, 1'b0);
    drive(1'b1, 16'h52, 1'b0);
    @(negedge clk);
    rst = 1'b1; s_data = 16'h53;
    @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_waddr", waddr, 0);
    check("rst_win", win, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; s_valid = 1'b0;
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(16'h61 + i), i == 5);
    idle(2);
    check_log("post_rst", 6, 'h61, 1);

    // Random traffic checked by the per-cycle model compare.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 149) == 0);
      start   = ($urandom_range(0, 7) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DW'($urandom);
      s_last  = (k == TOTAL - 1) ^ ($urandom_range(0, 24) == 0);
    end
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Streaming writer that fills the per-neuron weight memories of one layer over their write ports (write enable, write address, write data).
- Accepts a valid/ready stream of weight words, ordered neuron-major: all `numWeight` words of neuron 0, then neuron 1, and so on.
- Sits between the host/DMA weight stream and the layer's bank of weight memories. It is used when the design is built as RAM, not as a pretrained ROM.

Parameters:
- dataWidth, 16, width of one weight word.
- addressWidth, 10, width of the weight-memory address.
- numWeight, 784, weights per neuron; must be ≤ 2^addressWidth.
- numNeuron, 30, neurons (weight memories) in the layer.
- neuronWidth, 5, width of the neuron counter; must satisfy 2^neuronWidth ≥ numNeuron.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin loading a full layer.
- s_valid  input  1  stream word valid.
- s_ready  output  1  loader can accept a word.
- s_data  input  dataWidth  weight word.
- s_last  input  1  marks the final word of the layer.
- wen  output  numNeuron  one-hot write enable; bit n drives memory n.
- waddr  output  addressWidth  write address shared by all memories.
- win  output  dataWidth  write data shared by all memories.
- busy  output  1  high while in LOAD.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky framing error.

Behaviour:
- Interface: clk and rst only; reset is synchronous, active-high.
- Reset: state=IDLE, wcnt=0, ncnt=0.
  - All outputs 0: s_ready, wen, waddr, win, busy, done, err.
  - rst wins over every other input in the same cycle.
  - Reset mid-LOAD aborts the load. No wen is issued in the cycle after rst is sampled high.
- States: IDLE, LOAD, ERR. done is a registered pulse, not a state.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 → LOAD next cycle; wcnt, ncnt cleared to 0.
- LOAD:
  - s_ready=1, busy=1; start is ignored.
  - A beat is accepted on any cycle with s_valid && s_ready.
  - Accepted good beat, next cycle (1-cycle write latency, all registered):
    - wen = one-hot(ncnt);
    - waddr = wcnt, zero-extended to addressWidth;
    - win = s_data.
  - Cycles with no accepted beat: wen=0; waddr and win hold their last value.
  - Counters on an accepted good beat:
    - wcnt increments.
    - At wcnt==numWeight-1, wcnt wraps to 0 and ncnt increments.
    - No stall or bubble between neurons; back-to-back beats write every cycle.
  - Final beat is the one with ncnt==numNeuron-1 and wcnt==numWeight-1.
  - Final beat with s_last=1: written normally. Next cycle done=1 (coincident with the final wen), state=IDLE, counters cleared.
  - Final beat with s_last=0: framing error. The beat is not written (wen=0 next cycle); state → ERR.
  - Non-final beat with s_last=1: framing error. The beat is not written; state → ERR.
  - Words already written before an error stay in the memories; nothing is rolled back.
- ERR:
  - err=1, s_ready=0, busy=0, wen=0.
  - start=1 → LOAD with err cleared and counters zeroed, taking effect the same edge.
  - Otherwise ERR holds until rst.
- Outputs:
  - done is high for exactly one cycle per successful load.
  - err and done are never high together.
  - wen never has more than one bit set.

Test Plan:
- Small config (numWeight=3, numNeuron=2), start, then 6 back-to-back beats 0x0011..0x0016 with s_last on the 6th → writes, one per cycle:
  - wen=01: addr 0,1,2 ← 0x11,0x12,0x13;
  - wen=10: addr 0,1,2 ← 0x14,0x15,0x16;
  - done pulses exactly once, in the cycle of the last wen;
  - then IDLE, with s_ready=0.
- Same load with s_valid toggling 1,0,1,0 → identical writes and addresses. wen=0 in the cycles after gaps; waddr and win hold in those cycles.
- s_last asserted on beat 4 (neuron 1, addr 0) → beats 1-3 written, beat 4 not written. err=1 and s_ready=0 from the next cycle; no done.
- From ERR, start followed by a clean 6-beat load → err cleared on entry to LOAD, all 6 words written, done pulse.
- 6th beat without s_last → no write for beat 6, err=1. A 7th s_valid is not accepted (s_ready=0).
- rst asserted after beat 2 of a load, with s_valid held high:
  - all outputs 0 next cycle, no wen;
  - state IDLE, s_ready=0;
  - a subsequent start and full load begins at neuron 0, addr 0.
